mem_port_arbiter: RTL and testbench

- Shares one single-ported view of the unified instruction/data memory between the instruction-fetch (IF) requester and the load/store (LS) requester.
- The memory view has one combinational read port and one clocked write port with an active-low chip select.
- Sits between the core's fetch/LSU stages and the memory.
- Sequences byte-masked stores as read-modify-write (RMW).
- Arbitrates with LS priority plus an IF anti-starvation counter.

---
 rtl/mem_port_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported memory view (combinational read
//               port, clocked write port with active-low chip select) between
//               the instruction-fetch (IF) and load/store (LS) requesters.
//               LS has priority, but an anti-starvation counter forces an IF
//               grant after MAX_LSU_STREAK consecutive LS grants while IF
//               waits. Partial-mask stores run as a 2-cycle read-modify-write.
// Ports       : clk, rst (sync, active low)
//               if_req_i/if_addr_i -> if_gnt_o, if_rvalid_o, if_rdata_o
//               ls_req_i/ls_we_i/ls_addr_i/ls_wdata_i/ls_wmask_i
//                                  -> ls_gnt_o, ls_rvalid_o, ls_rdata_o,
//                                     ls_wdone_o
//               mem_raddr_o/mem_rdata_i (read), mem_w_cs_o/mem_waddr_o/
//               mem_wdata_o (write)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int MAX_LSU_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [63:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [63:0] if_rdata_o,
    input  logic        ls_req_i,
    input  logic        ls_we_i,
    input  logic [63:0] ls_addr_i,
    input  logic [63:0] ls_wdata_i,
    input  logic [7:0]  ls_wmask_i,
    output logic        ls_gnt_o,
    output logic        ls_rvalid_o,
    output logic [63:0] ls_rdata_o,
    output logic        ls_wdone_o,
    output logic [63:0] mem_raddr_o,
    input  logic [63:0] mem_rdata_i,
    output logic        mem_w_cs_o,
    output logic [63:0] mem_waddr_o,
    output logic [63:0] mem_wdata_o
);

    localparam int c_STREAK_W = $clog2(MAX_LSU_STREAK + 1);
    localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(MAX_LSU_STREAK);
    localparam logic [c_STREAK_W-1:0] c_STREAK_ONE = c_STREAK_W'(1);

    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_RMW_WR = 1'b1;

    logic [0:0]            r_state_q,     w_state_d;
    logic [c_STREAK_W-1:0] r_streak_q,    w_streak_d;
    logic [63:0]           r_rmw_addr_q,  w_rmw_addr_d;
    logic [63:0]           r_rmw_data_q,  w_rmw_data_d;
    logic                  r_if_rvalid_q, w_if_rvalid_d;
    logic [63:0]           r_if_rdata_q,  w_if_rdata_d;
    logic                  r_ls_rvalid_q, w_ls_rvalid_d;
    logic [63:0]           r_ls_rdata_q,  w_ls_rdata_d;
    logic                  r_ls_wdone_q,  w_ls_wdone_d;

    logic        w_idle;
    logic        w_in_rmw;
    logic        w_if_gnt;
    logic        w_ls_gnt;
    logic        w_ls_load;
    logic        w_st_full;
    logic        w_st_none;
    logic        w_st_part;
    logic [63:0] w_merged;

    // Grant and write decode. Everything is qualified with rst so that a
    // reset cycle neither grants nor pulls the write chip select low; this
    // is what drops a pending RMW write when reset lands in RMW_WR.
    always_comb begin
        w_idle    = rst && (r_state_q == c_ST_IDLE);
        w_in_rmw  = rst && (r_state_q == c_ST_RMW_WR);
        w_ls_gnt  = w_idle && ls_req_i && !(if_req_i && (r_streak_q == c_STREAK_MAX));
        w_if_gnt  = w_idle && if_req_i && !w_ls_gnt;
        w_ls_load = w_ls_gnt && !ls_we_i;
        w_st_full = w_ls_gnt && ls_we_i && (ls_wmask_i == 8'hFF);
        w_st_none = w_ls_gnt && ls_we_i && (ls_wmask_i == 8'h00);
        w_st_part = w_ls_gnt && ls_we_i && !w_st_full && !w_st_none;
    end

    // Byte merge of store data over the word currently read from memory
    always_comb begin
        w_merged = '0;
        for (int i = 0; i < 8; i++) begin
            w_merged[8*i +: 8] = ls_wmask_i[i] ? ls_wdata_i[8*i +: 8]
                                               : mem_rdata_i[8*i +: 8];
        end
    end

    // Memory port drive
    always_comb begin
        mem_raddr_o = '0;
        if (w_if_gnt) begin
            mem_raddr_o = if_addr_i;
        end else if (w_ls_gnt) begin
            mem_raddr_o = ls_addr_i;
        end else if (w_in_rmw) begin
            mem_raddr_o = r_rmw_addr_q;
        end

        mem_w_cs_o  = 1'b1;
        mem_waddr_o = '0;
        mem_wdata_o = '0;
        if (w_st_full) begin
            mem_w_cs_o  = 1'b0;
            mem_waddr_o = ls_addr_i;
            mem_wdata_o = ls_wdata_i;
        end else if (w_in_rmw) begin
            mem_w_cs_o  = 1'b0;
            mem_waddr_o = r_rmw_addr_q;
            mem_wdata_o = r_rmw_data_q;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_d = w_st_part ? c_ST_RMW_WR : c_ST_IDLE;

        // The streak only measures LS grants that IF actually waited through
        w_streak_d = r_streak_q;
        if (!if_req_i || w_if_gnt) begin
            w_streak_d = '0;
        end else if (w_ls_gnt && (r_streak_q != c_STREAK_MAX)) begin
            w_streak_d = r_streak_q + c_STREAK_ONE;
        end

        w_rmw_addr_d = r_rmw_addr_q;
        w_rmw_data_d = r_rmw_data_q;
        if (w_st_part) begin
            w_rmw_addr_d = ls_addr_i;
            w_rmw_data_d = w_merged;
        end

        w_if_rvalid_d = w_if_gnt;
        w_if_rdata_d  = w_if_gnt ? mem_rdata_i : r_if_rdata_q;
        w_ls_rvalid_d = w_ls_load;
        w_ls_rdata_d  = w_ls_load ? mem_rdata_i : r_ls_rdata_q;
        w_ls_wdone_d  = w_st_full || w_st_none || w_in_rmw;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_q     <= c_ST_IDLE;
            r_streak_q    <= '0;
            r_rmw_addr_q  <= '0;
            r_rmw_data_q  <= '0;
            r_if_rvalid_q <= 1'b0;
            r_if_rdata_q  <= '0;
            r_ls_rvalid_q <= 1'b0;
            r_ls_rdata_q  <= '0;
            r_ls_wdone_q  <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_streak_q    <= w_streak_d;
            r_rmw_addr_q  <= w_rmw_addr_d;
            r_rmw_data_q  <= w_rmw_data_d;
            r_if_rvalid_q <= w_if_rvalid_d;
            r_if_rdata_q  <= w_if_rdata_d;
            r_ls_rvalid_q <= w_ls_rvalid_d;
            r_ls_rdata_q  <= w_ls_rdata_d;
            r_ls_wdone_q  <= w_ls_wdone_d;
        end
    end

    assign if_gnt_o    = w_if_gnt;
    assign ls_gnt_o    = w_ls_gnt;
    assign if_rvalid_o = r_if_rvalid_q;
    assign if_rdata_o  = r_if_rdata_q;
    assign ls_rvalid_o = r_ls_rvalid_q;
    assign ls_rdata_o  = r_ls_rdata_q;
    assign ls_wdone_o  = r_ls_wdone_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. A behavioural model
//               predicts grants and write-port activity each cycle and queues
//               the expected responses; a monitor pops and compares them when
//               the DUT pulses rvalid/wdone.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int MAX_LSU_STREAK = 4;
    localparam int c_NWORDS       = 80;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_gnt, if_rvalid;
    logic [63:0] if_addr, if_rdata;
    logic        ls_req, ls_we, ls_gnt, ls_rvalid, ls_wdone;
    logic [63:0] ls_addr, ls_wdata, ls_rdata;
    logic [7:0]  ls_wmask;
    logic [63:0] mem_raddr, mem_rdata, mem_waddr, mem_wdata;
    logic        mem_w_cs;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_LSU_STREAK(MAX_LSU_STREAK)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_addr_i(ls_addr),
        .ls_wdata_i(ls_wdata), .ls_wmask_i(ls_wmask), .ls_gnt_o(ls_gnt),
        .ls_rvalid_o(ls_rvalid), .ls_rdata_o(ls_rdata), .ls_wdone_o(ls_wdone),
        .mem_raddr_o(mem_raddr), .mem_rdata_i(mem_rdata),
        .mem_w_cs_o(mem_w_cs), .mem_waddr_o(mem_waddr), .mem_wdata_o(mem_wdata)
    );

    // Memory behind the arbiter, with a backdoor load port for initialisation
    logic [63:0] mem [0:255];
    logic        bd_we = 1'b0;
    logic [7:0]  bd_idx = '0;
    logic [63:0] bd_data = '0;
    assign mem_rdata = mem[mem_raddr[10:3]];
    always @(posedge clk) begin
        if (bd_we) mem[bd_idx] <= bd_data;
        else if (!mem_w_cs) mem[mem_waddr[10:3]] <= mem_wdata;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    typedef struct { int due; logic [63:0] data; } resp_t;
    resp_t       q_if[$], q_ls[$], q_wd[$];
    logic [63:0] ref_mem [0:255];
    int          run = 0;        // LS grants IF has waited through
    bit          busy = 1'b0;    // next cycle completes a partial store
    logic [63:0] pend_addr, pend_data;
    int          checks = 0, errors = 0;
    bit          e_if, e_ls, a_if, a_ls;

    function automatic int idx(input logic [63:0] a);
        return int'(a[10:3]);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive the inputs, predict, and compare the
    // combinational outputs of the cycle.
    task automatic step(input bit ir, input logic [63:0] ia, input bit lr, input bit we,
                        input logic [63:0] la, input logic [63:0] wd,
                        input logic [7:0] m, input bit r);
        logic        x_cs;
        logic [63:0] x_wa, x_wd, x_ra, mg, old;
        @(posedge clk);
        #2;
        if_req = ir; if_addr = ia; ls_req = lr; ls_we = we;
        ls_addr = la; ls_wdata = wd; ls_wmask = m; rst = r;
        #1;
        e_if = 0; e_ls = 0; x_cs = 1; x_wa = 0; x_wd = 0; x_ra = 0;
        if (!r) begin
            run = 0; busy = 0;
            q_if.delete(); q_ls.delete(); q_wd.delete();
        end else if (busy) begin
            x_cs = 0; x_wa = pend_addr; x_wd = pend_data; x_ra = pend_addr;
            ref_mem[idx(pend_addr)] = pend_data;
            q_wd.push_back('{cyc + 1, 64'h0});
            busy = 0;
            if (!ir) run = 0;
        end else begin
            e_ls = lr && !(ir && run == MAX_LSU_STREAK);
            e_if = ir && !e_ls;
            if (!ir || e_if) run = 0;
            else if (e_ls && run < MAX_LSU_STREAK) run++;
            if (e_if) begin
                x_ra = ia;
                q_if.push_back('{cyc + 1, ref_mem[idx(ia)]});
            end
            if (e_ls) begin
                x_ra = la;
                if (!we) begin
                    q_ls.push_back('{cyc + 1, ref_mem[idx(la)]});
                end else if (m == 8'hFF) begin
                    x_cs = 0; x_wa = la; x_wd = wd;
                    ref_mem[idx(la)] = wd;
                    q_wd.push_back('{cyc + 1, 64'h0});
                end else if (m == 8'h00) begin
                    q_wd.push_back('{cyc + 1, 64'h0});
                end else begin
                    old = ref_mem[idx(la)];
                    for (int i = 0; i < 8; i++)
                        mg[8*i +: 8] = m[i] ? wd[8*i +: 8] : old[8*i +: 8];
                    pend_addr = la; pend_data = mg; busy = 1;
                end
            end
        end
        a_if = if_gnt; a_ls = ls_gnt;
        chk("if_gnt", {63'h0, if_gnt}, {63'h0, e_if});
        chk("ls_gnt", {63'h0, ls_gnt}, {63'h0, e_ls});
        chk("mem_w_cs", {63'h0, mem_w_cs}, {63'h0, x_cs});
        chk("mem_waddr", mem_waddr, x_wa);
        chk("mem_wdata", mem_wdata, x_wd);
        chk("mem_raddr", mem_raddr, x_ra);
    endtask

    task automatic idle_step();
        step(0, 64'h0, 0, 0, 64'h0, 64'h0, 8'h0, 1);
    endtask

    // Issue an LS operation and hold it until the model says it is granted
    task automatic ls_op(input bit we, input logic [63:0] a, input logic [63:0] wd,
                         input logic [7:0] m);
        for (int n = 0; n < 20; n++) begin
            step(0, 64'h0, 1, we, a, wd, m, 1);
            if (e_ls) return;
        end
        chk("ls_op_timeout", 64'h0, 64'h1);
    endtask

    // ---------------- monitor ----------------
    function automatic resp_t pop(input int sel);
        resp_t e;
        case (sel)
            0:       e = q_if.pop_front();
            1:       e = q_ls.pop_front();
            default: e = q_wd.pop_front();
        endcase
        return e;
    endfunction

    task automatic mon_one(input int sel, input logic v, input logic [63:0] d, input string nm);
        resp_t e;
        int    n;
        n = (sel == 0) ? q_if.size() : (sel == 1) ? q_ls.size() : q_wd.size();
        if (v === 1'b1) begin
            checks++;
            if (n == 0) begin
                errors++;
                $display("FAIL %s unexpected pulse actual=1 required=0 (cycle %0d)", nm, cyc);
            end else begin
                e = pop(sel);
                if (e.due != cyc || (sel != 2 && d !== e.data)) begin
                    errors++;
                    $display("FAIL %s actual cycle %0d data %h required cycle %0d data %h",
                             nm, cyc, d, e.due, e.data);
                end
            end
        end else if (n > 0) begin
            e = (sel == 0) ? q_if[0] : (sel == 1) ? q_ls[0] : q_wd[0];
            if (e.due <= cyc) begin
                checks++; errors++;
                $display("FAIL %s missing pulse actual=0 required=1 (cycle %0d)", nm, cyc);
                void'(pop(sel));
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            mon_one(0, if_rvalid, if_rdata, "if_resp");
            mon_one(1, ls_rvalid, ls_rdata, "ls_resp");
            mon_one(2, ls_wdone, 64'h0, "ls_wdone");
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [11:0] pat;
        logic [63:0] v, pre;
        bit          ip, lp, lwe;
        logic [63:0] ia, la, lwd;
        logic [7:0]  lm;

        rst = 0; if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0;
        ls_addr = 0; ls_wdata = 0; ls_wmask = 0;

        // Load memory through the backdoor while held in reset
        for (int i = 0; i < c_NWORDS; i++) begin
            v = {$urandom, $urandom};
            if (i == 32) v = 64'h1122334455667788;
            @(posedge clk); #1;
            bd_we = 1; bd_idx = 8'(i); bd_data = v; ref_mem[i] = v;
        end
        @(posedge clk); #1;
        bd_we = 0;
        @(posedge clk); #1;
        chk("rst_if_rvalid", {63'h0, if_rvalid}, 64'h0);
        chk("rst_ls_rvalid", {63'h0, ls_rvalid}, 64'h0);
        chk("rst_ls_wdone", {63'h0, ls_wdone}, 64'h0);
        chk("rst_if_rdata", if_rdata, 64'h0);
        chk("rst_ls_rdata", ls_rdata, 64'h0);

        // IF read of a known word
        step(1, 64'h100, 0, 0, 64'h0, 64'h0, 8'h0, 1);
        chk("tp_if_gnt", {63'h0, a_if}, 64'h1);
        idle_step();
        chk("tp_if_rdata", if_rdata, 64'h1122334455667788);

        // Full store then load back
        ls_op(1, 64'h200, 64'hAAAA_BBBB_CCCC_DDDD, 8'hFF);
        idle_step();
        chk("tp_full_mem", mem[64], 64'hAAAA_BBBB_CCCC_DDDD);
        ls_op(0, 64'h200, 64'h0, 8'h0);
        idle_step();
        chk("tp_full_load", ls_rdata, 64'hAAAA_BBBB_CCCC_DDDD);

        // Partial store as RMW, with both requesters knocking during RMW_WR
        ls_op(1, 64'h200, 64'h0, 8'hFF);
        ls_op(1, 64'h200, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        step(1, 64'h108, 1, 0, 64'h200, 64'h0, 8'h0, 1);
        chk("tp_rmw_no_gnt", {62'h0, a_if, a_ls}, 64'h0);
        ls_op(0, 64'h200, 64'h0, 8'h0);
        idle_step();
        chk("tp_rmw_mem", mem[64], 64'h0000_0000_FFFF_FFFF);
        chk("tp_rmw_load", ls_rdata, 64'h0000_0000_FFFF_FFFF);

        // Empty mask: no write at all
        ls_op(1, 64'h200, 64'h1234_5678_9ABC_DEF0, 8'h00);
        idle_step();
        chk("tp_mask0_mem", mem[64], 64'h0000_0000_FFFF_FFFF);

        // Starvation guard: both loads held for 12 cycles
        idle_step();
        for (int i = 0; i < 12; i++) begin
            step(1, 64'h40, 1, 0, 64'h48, 64'h0, 8'h0, 1);
            pat[11-i] = a_ls;
        end
        chk("tp_streak_pattern", {52'h0, pat}, {52'h0, 12'b1111_0111_1011});
        idle_step();

        // Reset landing in RMW_WR drops the write and the wdone
        pre = mem[65];
        ls_op(1, 64'h208, 64'h5555_6666_7777_8888, 8'h3C);
        step(0, 64'h0, 0, 0, 64'h0, 64'h0, 8'h0, 0);
        @(posedge clk); #1;
        chk("rr_if_rvalid", {63'h0, if_rvalid}, 64'h0);
        chk("rr_ls_rvalid", {63'h0, ls_rvalid}, 64'h0);
        chk("rr_ls_wdone", {63'h0, ls_wdone}, 64'h0);
        chk("rr_if_rdata", if_rdata, 64'h0);
        chk("rr_ls_rdata", ls_rdata, 64'h0);
        chk("rr_mem_w_cs", {63'h0, mem_w_cs}, 64'h1);
        chk("rr_mem_raddr", mem_raddr, 64'h0);
        chk("rr_mem", mem[65], pre);
        idle_step();

        // Randomised traffic; requesters hold until granted
        ip = 0; lp = 0; ia = 0; la = 0; lwe = 0; lwd = 0; lm = 0;
        for (int i = 0; i < 600; i++) begin
            if (!ip && ($urandom_range(0, 2) != 0)) begin
                ip = 1;
                ia = {53'h0, 8'($urandom_range(0, c_NWORDS - 1)), 3'($urandom)};
            end
            if (!lp && ($urandom_range(0, 2) != 0)) begin
                lp = 1; lwe = 1'($urandom);
                la = {53'h0, 8'($urandom_range(0, c_NWORDS - 1)), 3'($urandom)};
                lwd = {$urandom, $urandom};
                case ($urandom_range(0, 3))
                    0:       lm = 8'hFF;
                    1:       lm = 8'h00;
                    default: lm = 8'($urandom);
                endcase
            end
            step(ip, ia, lp, lwe, la, lwd, lm, 1);
            if (e_if) ip = 0;
            if (e_ls) lp = 0;
        end
        for (int i = 0; i < 4; i++) idle_step();

        chk("drain_queues", 64'(q_if.size() + q_ls.size() + q_wd.size()), 64'h0);
        for (int i = 0; i < c_NWORDS; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
